// File: rtl/fifo_pkg.sv
// Shared read-mode constants and parameter legality helpers for fifo_level.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Thresholds must land inside the reachable occupancy range for the chosen depth.
  function automatic bit thresholds_legal(int unsigned depth_log2, int unsigned almost_full,
                                          int unsigned almost_empty);
    int unsigned cap;
    cap = 1 << depth_log2;
    return (almost_full >= 1) && (almost_full <= cap) && (almost_empty <= cap - 1);
  endfunction

  function automatic bit mode_legal(int unsigned fwft);
    return (fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT);
  endfunction

endpackage

// File: rtl/fifo_level_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
interface fifo_level_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) ();

  logic                  flush;
  logic                  write;
  logic [WIDTH-1:0]      write_data;
  logic                  read;
  logic                  clear_err;
  logic [WIDTH-1:0]      read_data;
  logic                  read_valid;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write, write_data, read, clear_err,
    input  read_data, read_valid, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  flush, write, write_data, read, clear_err,
    output read_data, read_valid, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  Clock,
  input  logic                  write_en,
  input  logic [DEPTH_LOG2-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge Clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags and flush.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned ALMOST_FULL  = 12,
  parameter int unsigned ALMOST_EMPTY = 2,
  parameter int unsigned FWFT         = FIFO_MODE_FWFT
) (
  input logic        Clock,
  input logic        ResetN,
  fifo_level_if.slave bus
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] CapCnt = CW'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] AfCnt  = CW'(ALMOST_FULL);
  localparam logic [DEPTH_LOG2:0] AeCnt  = CW'(ALMOST_EMPTY);

  if (!thresholds_legal(DEPTH_LOG2, ALMOST_FULL, ALMOST_EMPTY)) begin : gen_bad_thresholds
    $error("fifo_level: ALMOST_FULL/ALMOST_EMPTY outside legal range");
  end
  if (!mode_legal(FWFT)) begin : gen_bad_mode
    $error("fifo_level: FWFT must be 0 or 1");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  almost_empty_q, almost_empty_d, almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_acc, wr_acc, mem_we;
  logic [WIDTH-1:0]      mem_rdata;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = bus.read & ~empty_q;
  assign wr_acc = bus.write & (~full_q | rd_acc);
  assign mem_we = wr_acc & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    // Flags track count_d so they change on the same edge as count.
    empty_d        = (count_d == '0);
    full_d         = (count_d == CapCnt);
    almost_empty_d = (count_d <= AeCnt);
    almost_full_d  = (count_d >= AfCnt);

    // Setting wins over clear_err; flush suppresses new errors but keeps old ones.
    overflow_d  = (bus.write & ~wr_acc & ~bus.flush) | (overflow_q & ~bus.clear_err);
    underflow_d = (bus.read & empty_q & ~bus.flush) | (underflow_q & ~bus.clear_err);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .Clock      (Clock),
    .write_en   (mem_we),
    .write_addr (wr_ptr_q),
    .write_data (bus.write_data),
    .read_addr  (rd_ptr_q),
    .read_data  (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : gen_fwft
    assign bus.read_data  = mem_rdata;
    assign bus.read_valid = ~empty_q;
  end else begin : gen_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge Clock) begin
      if (!ResetN) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (bus.flush) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_rdata;
      end
    end

    assign bus.read_data  = rdata_q;
    assign bus.read_valid = rvalid_q;
  end

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// Drives an FWFT and a standard-mode fifo_level in lockstep against a queue-based model.
module tb_fifo_level;

  localparam int unsigned W   = 8;
  localparam int unsigned DL  = 2;
  localparam int unsigned CAP = 4;
  localparam int unsigned AF  = 3;
  localparam int unsigned AE  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_level_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus_f ();
  fifo_level_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus_s ();

  fifo_level #(
    .WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(1)
  ) u_fwft (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus_f)
  );

  fifo_level #(
    .WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(0)
  ) u_std (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, sticky flags, last popped value.
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("F.count", 32'(bus_f.count), n);
    chk("S.count", 32'(bus_s.count), n);
    chk("F.empty", 32'(bus_f.empty), 32'(n == 0));
    chk("S.empty", 32'(bus_s.empty), 32'(n == 0));
    chk("F.full", 32'(bus_f.full), 32'(n == CAP));
    chk("S.full", 32'(bus_s.full), 32'(n == CAP));
    chk("F.almost_empty", 32'(bus_f.almost_empty), 32'(n <= AE));
    chk("S.almost_empty", 32'(bus_s.almost_empty), 32'(n <= AE));
    chk("F.almost_full", 32'(bus_f.almost_full), 32'(n >= AF));
    chk("S.almost_full", 32'(bus_s.almost_full), 32'(n >= AF));
    chk("F.overflow", 32'(bus_f.overflow), 32'(m_ovf));
    chk("S.overflow", 32'(bus_s.overflow), 32'(m_ovf));
    chk("F.underflow", 32'(bus_f.underflow), 32'(m_unf));
    chk("S.underflow", 32'(bus_s.underflow), 32'(m_unf));
    chk("F.read_valid", 32'(bus_f.read_valid), 32'(n != 0));
    if (n != 0) chk("F.read_data", 32'(bus_f.read_data), 32'(q[0]));
    chk("S.read_valid", 32'(bus_s.read_valid), 32'(m_rv));
    chk("S.read_data", 32'(bus_s.read_data), 32'(m_rd));
  endtask

  task automatic step(bit w, logic [7:0] wd, bit r, bit fl, bit ce, bit rn);
    bit rd_acc, wr_acc, ov_set, un_set;
    @(negedge clk);
    rst_n            = rn;
    bus_f.write      = w;  bus_s.write      = w;
    bus_f.write_data = wd; bus_s.write_data = wd;
    bus_f.read       = r;  bus_s.read       = r;
    bus_f.flush      = fl; bus_s.flush      = fl;
    bus_f.clear_err  = ce; bus_s.clear_err  = ce;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;
    end else if (fl) begin
      q.delete();
      m_rv = 0;
      if (ce) begin m_ovf = 0; m_unf = 0; end
    end else begin
      rd_acc = r && (q.size() != 0);
      wr_acc = w && ((q.size() < CAP) || rd_acc);
      ov_set = w && !wr_acc;
      un_set = r && (q.size() == 0);
      if (rd_acc) begin
        m_rd = q.pop_front();
        m_rv = 1;
      end else begin
        m_rv = 0;
      end
      if (wr_acc) q.push_back(wd);
      m_ovf = ov_set || (m_ovf && !ce);
      m_unf = un_set || (m_unf && !ce);
    end
    #1;
    check_all();
  endtask

  task automatic wr(logic [7:0] d);  step(1, d, 0, 0, 0, 1); endtask
  task automatic rd();               step(0, 8'h00, 1, 0, 0, 1); endtask
  task automatic clr();              step(0, 8'h00, 0, 0, 1, 1); endtask

  initial begin
    rst_n = 1'b0;
    bus_f.write = 0; bus_f.write_data = '0; bus_f.read = 0; bus_f.flush = 0; bus_f.clear_err = 0;
    bus_s.write = 0; bus_s.write_data = '0; bus_s.read = 0; bus_s.flush = 0; bus_s.clear_err = 0;
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;

    // Reset state
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);

    // Fill to full, then overflow
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wr(8'h55);

    // Drain in order, then underflow
    rd(); rd(); rd(); rd();
    rd();
    clr();

    // Full with simultaneous read and write
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    step(1, 8'h66, 1, 0, 0, 1);
    rd(); rd(); rd(); rd();

    // Empty with simultaneous read and write
    step(1, 8'h77, 1, 0, 0, 1);
    rd();

    // Error set in the same cycle as clear_err: set wins
    step(0, 8'h00, 1, 0, 1, 1);
    clr();

    // Random mixed traffic; exercises pointer wrap and full/empty boundaries
    for (int i = 0; i < 300; i++) begin
      bit w, r, ce;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      ce = ($urandom_range(0, 99) < 5);
      step(w, 8'($urandom), r, 0, ce, 1);
    end
    clr();

    // Bursts of ten writes and ten reads
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 10; i++) step($urandom_range(0, 3) != 0, 8'($urandom), 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 8'h00, $urandom_range(0, 3) != 0, 0, 0, 1);
      clr();
    end

    // Flush beats a concurrent write and raises no error
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    step(1, 8'hA4, 0, 1, 0, 1);
    wr(8'hB1); rd();

    // Sticky flags survive flush
    rd();
    wr(8'hC1);
    step(0, 8'h00, 0, 1, 0, 1);
    clr();

    // Reset mid-stream
    wr(8'hD1); wr(8'hD2); rd();
    step(1, 8'hD3, 1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    wr(8'hE1); rd();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
